// File: rtl/syn_deser_if.sv
// -----------------------------------------------------------------------------
// syn_deser_if
//   Bundle of the serial-input / parallel-output signals of syn_deser.
//
//   sin        serial data line, idles high
//   sin_en     bit strobe; sin only matters on clock edges where this is high
//   out        last correctly received word
//   out_valid  one-cycle pulse when out takes a new word
//   busy       high while a frame is being received
//   err        one-cycle pulse when a frame is rejected
//
//   master : the side that drives the serial line and watches the results
//   slave  : the deserializer itself
// -----------------------------------------------------------------------------
interface syn_deser_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_en;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;
    logic             err;

    modport master (
        output sin,
        output sin_en,
        input  out,
        input  out_valid,
        input  busy,
        input  err
    );

    modport slave (
        input  sin,
        input  sin_en,
        output out,
        output out_valid,
        output busy,
        output err
    );
endinterface

// File: rtl/syn_deser.sv
// -----------------------------------------------------------------------------
// syn_deser
//   Strobed serial-to-parallel receiver. A frame is a 0 start bit, WIDTH data
//   bits MSB first, an optional even-parity bit, and a 1 stop bit. Only clock
//   edges with sin_en high advance the receiver.
//
//   Parameters
//     WIDTH      data bits per frame (2..16)
//     PARITY_EN  1 = an even-parity bit follows the data bits
//
//   Ports
//     clk        rising-edge clock
//     rst_n      synchronous active-low reset
//     bus        syn_deser_if.slave: sin, sin_en in; out, out_valid, busy,
//                err out (all outputs registered)
// -----------------------------------------------------------------------------
module syn_deser #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b0
) (
    input logic        clk,
    input logic        rst_n,
    syn_deser_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic             parity_bad;

    // Single-process FSM. The pulses default low every cycle, so an edge with
    // sin_en low drops them while every other register simply holds.
    // busy is kept as its own register and tracks state != IDLE exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            parity_bad    <= 1'b0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.err       <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.err       <= 1'b0;
            if (bus.sin_en) begin
                case (state)
                    IDLE: begin
                        if (!bus.sin) begin
                            state      <= DATA;
                            bit_cnt    <= '0;
                            parity_bad <= 1'b0;
                            bus.busy   <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_reg <= {shift_reg[WIDTH-2:0], bus.sin};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                            state <= PARITY_EN ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        // Even parity: data bits plus the parity bit must XOR to 0.
                        parity_bad <= (^shift_reg) ^ bus.sin;
                        state      <= STOP;
                    end
                    STOP: begin
                        if (bus.sin && !parity_bad) begin
                            bus.out       <= shift_reg;
                            bus.out_valid <= 1'b1;
                        end else begin
                            bus.err <= 1'b1;
                        end
                        parity_bad <= 1'b0;
                        state      <= IDLE;
                        bus.busy   <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_syn_deser.sv
// -----------------------------------------------------------------------------
// tb_syn_deser
//   Directed bench for syn_deser with WIDTH=4. dut0 runs without parity,
//   dut1 with even parity; both share clock and reset. Frames are driven
//   bit by bit and results are compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_syn_deser;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    int vc0, ec0, vc1, ec1, both_hi;
    int vc_snap, ec_snap;

    syn_deser_if #(.WIDTH(4)) bus0 ();
    syn_deser_if #(.WIDTH(4)) bus1 ();

    syn_deser #(.WIDTH(4), .PARITY_EN(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    syn_deser #(.WIDTH(4), .PARITY_EN(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus0.out_valid) vc0 <= vc0 + 1;
        if (bus0.err)       ec0 <= ec0 + 1;
        if (bus1.out_valid) vc1 <= vc1 + 1;
        if (bus1.err)       ec1 <= ec1 + 1;
        if ((bus0.out_valid && bus0.err) || (bus1.out_valid && bus1.err))
            both_hi <= both_hi + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Sends nbits of 'bits' MSB first to the selected DUT, one strobe per bit,
    // with 'gap' strobe-less cycles after each bit. Returns at the negedge
    // right after the last strobed edge with the line idle.
    task automatic applyStimulus(input int sel, input logic [15:0] bits,
                                 input int nbits, input int gap);
        for (int i = nbits - 1; i >= 0; i--) begin
            @(negedge clk);
            if (sel == 0) begin bus0.sin = bits[i]; bus0.sin_en = 1'b1; end
            else          begin bus1.sin = bits[i]; bus1.sin_en = 1'b1; end
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                if (sel == 0) bus0.sin_en = 1'b0; else bus1.sin_en = 1'b0;
            end
        end
        @(negedge clk);
        if (sel == 0) begin bus0.sin_en = 1'b0; bus0.sin = 1'b1; end
        else          begin bus1.sin_en = 1'b0; bus1.sin = 1'b1; end
    endtask

    task automatic snap0();
        vc_snap = vc0;
        ec_snap = ec0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        vc0 = 0; ec0 = 0; vc1 = 0; ec1 = 0; both_hi = 0;
        bus0.sin = 1'b1; bus0.sin_en = 1'b0;
        bus1.sin = 1'b1; bus1.sin_en = 1'b0;
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_out0",   32'(bus0.out), 32'h0);
        checkOutput("rst_valid0", 32'(bus0.out_valid), 32'h0);
        checkOutput("rst_err0",   32'(bus0.err), 32'h0);
        checkOutput("rst_busy0",  32'(bus0.busy), 32'h0);
        checkOutput("rst_out1",   32'(bus1.out), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Continuous strobe: 0,1,0,1,0,1 -> 4'hA
        snap0();
        applyStimulus(0, 16'b010101, 6, 0);
        checkOutput("a_latency_pulse", 32'(bus0.out_valid), 32'h1);
        checkOutput("a_out", 32'(bus0.out), 32'hA);
        checkOutput("a_busy_after", 32'(bus0.busy), 32'h0);
        @(negedge clk);
        checkOutput("a_pulse_drop", 32'(bus0.out_valid), 32'h0);
        @(negedge clk);
        checkOutput("a_valid_cnt", 32'(vc0 - vc_snap), 32'h1);
        checkOutput("a_err_cnt", 32'(ec0 - ec_snap), 32'h0);

        // Bad stop bit: 0,1,1,1,1,0 -> err, out keeps 4'hA
        snap0();
        applyStimulus(0, 16'b011110, 6, 0);
        checkOutput("badstop_err", 32'(bus0.err), 32'h1);
        checkOutput("badstop_out", 32'(bus0.out), 32'hA);
        repeat (2) @(negedge clk);
        checkOutput("badstop_err_cnt", 32'(ec0 - ec_snap), 32'h1);
        checkOutput("badstop_valid_cnt", 32'(vc0 - vc_snap), 32'h0);
        checkOutput("badstop_busy", 32'(bus0.busy), 32'h0);

        // Strobe every third cycle: 0,1,1 | pause | 0,0,1 -> 4'hC
        snap0();
        applyStimulus(0, 16'b011, 3, 2);
        repeat (4) @(negedge clk);
        checkOutput("slow_busy_held", 32'(bus0.busy), 32'h1);
        checkOutput("slow_out_held", 32'(bus0.out), 32'hA);
        applyStimulus(0, 16'b001, 3, 2);
        repeat (2) @(negedge clk);
        checkOutput("slow_out", 32'(bus0.out), 32'hC);
        checkOutput("slow_valid_cnt", 32'(vc0 - vc_snap), 32'h1);
        checkOutput("slow_busy_after", 32'(bus0.busy), 32'h0);

        // Back-to-back 4'h5 then 4'h3, no idle strobe between
        snap0();
        applyStimulus(0, 16'b001011000111, 12, 0);
        checkOutput("b2b_out", 32'(bus0.out), 32'h3);
        repeat (2) @(negedge clk);
        checkOutput("b2b_valid_cnt", 32'(vc0 - vc_snap), 32'h2);
        checkOutput("b2b_err_cnt", 32'(ec0 - ec_snap), 32'h0);

        // Parity DUT: data F, parity 0 -> good
        applyStimulus(1, 16'b0111101, 7, 0);
        checkOutput("par_good_pulse", 32'(bus1.out_valid), 32'h1);
        checkOutput("par_good_out", 32'(bus1.out), 32'hF);
        // Same data with parity 1 -> rejected
        applyStimulus(1, 16'b0111111, 7, 0);
        checkOutput("par_bad_err", 32'(bus1.err), 32'h1);
        checkOutput("par_bad_valid", 32'(bus1.out_valid), 32'h0);
        checkOutput("par_bad_out", 32'(bus1.out), 32'hF);
        // Data 1 with parity 1 -> good
        applyStimulus(1, 16'b0000111, 7, 0);
        checkOutput("par_odd_out", 32'(bus1.out), 32'h1);
        repeat (2) @(negedge clk);
        checkOutput("par_valid_cnt", 32'(vc1), 32'h2);
        checkOutput("par_err_cnt", 32'(ec1), 32'h1);

        // Reset mid-frame after two data bits, strobe active during reset
        snap0();
        applyStimulus(0, 16'b000, 3, 0);
        checkOutput("mid_busy", 32'(bus0.busy), 32'h1);
        rst_n = 1'b0;
        bus0.sin = 1'b0; bus0.sin_en = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("mid_rst_busy", 32'(bus0.busy), 32'h0);
        checkOutput("mid_rst_out", 32'(bus0.out), 32'h0);
        bus0.sin = 1'b1; bus0.sin_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_nopulse", 32'((vc0 - vc_snap) + (ec0 - ec_snap)), 32'h0);
        applyStimulus(0, 16'b000101, 6, 0);
        checkOutput("post_rst_out", 32'(bus0.out), 32'h2);
        repeat (2) @(negedge clk);
        checkOutput("post_rst_valid_cnt", 32'(vc0 - vc_snap), 32'h1);
        checkOutput("post_rst_err_cnt", 32'(ec0 - ec_snap), 32'h0);
        checkOutput("par_out_after_rst", 32'(bus1.out), 32'h0);

        checkOutput("never_both_pulses", 32'(both_hi), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/syn_deser.md
SYN_DESER -- requirements
Module: syn_deser

Interface
REQ-001 Parameter: WIDTH, 4, number of data bits per frame (2..16).
REQ-002 Parameter: PARITY_EN, 0, when 1 an even-parity bit follows the data bits.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: sin  input  1  serial data line; idles high.
REQ-006 Port: sin_en  input  1  bit strobe; sin is sampled only on edges where sin_en=1.
REQ-007 Port: out  output  WIDTH  last correctly received word, registered.
REQ-008 Port: out_valid  output  1  one-cycle pulse: out updated with a new word.
REQ-009 Port: busy  output  1  high while a frame is in progress (state != IDLE).
REQ-010 Port: err  output  1  one-cycle pulse: frame rejected (bad stop or parity).

Function
REQ-011 Frame format SHALL be: start bit 0, WIDTH data bits MSB first, parity bit if PARITY_EN=1, stop bit 1.
REQ-012 FSM SHALL have states IDLE, DATA, PARITY, STOP; transitions occur only on edges with sin_en=1.
REQ-013 IDLE: sin=0 -> DATA, bit counter cleared; sin=1 -> stay IDLE.
REQ-014 DATA: shift sin into shift register LSB side, increment counter; after WIDTH-th bit -> PARITY if PARITY_EN=1, else STOP.
REQ-015 PARITY: sample sin, flag mismatch if XOR(data bits, sin) != 0 -> STOP.
REQ-016 STOP: sin=1 and no parity mismatch -> out <= shift register, out_valid=1 for one cycle, -> IDLE.
REQ-017 STOP: sin=0 or parity mismatch -> err=1 for one cycle, out unchanged, -> IDLE.
REQ-018 out_valid and err SHALL both be registered, visible in the cycle after the edge sampling the stop bit; never both high.
REQ-019 Edges with sin_en=0 SHALL hold all state, counter, and shift register; out_valid/err deassert.
REQ-020 Back-to-back frames: a start bit on the first sin_en edge after STOP SHALL be accepted with no gap.
REQ-021 out SHALL hold its value indefinitely until the next valid frame; an erroneous frame never modifies it.
REQ-022 busy SHALL be 1 from the edge entering DATA through the edge leaving STOP.
REQ-023 Latency: start bit to out_valid = WIDTH+2 (+1 if PARITY_EN) sin_en strobes, plus one clock.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force state IDLE, counter 0, shift register 0, out=0, out_valid=0, err=0, busy=0.
REQ-025 Reset mid-frame SHALL abort the frame without out_valid or err; first frame after release is received normally.
REQ-026 Reset SHALL take priority over sin_en and sin on the same edge.

Verification (WIDTH=4)
REQ-027 PARITY_EN=0, sin_en=1 every cycle, bits 0,1,0,1,0,1 -> out=4'hA, out_valid one cycle, err=0, busy low after.
REQ-028 sin_en pulsed every 3rd cycle, frame 0,1,1,0,0,1 -> out=4'hC, identical result to continuous strobe; state held between strobes.
REQ-029 Bad stop: 0,1,1,1,1,0 after out=4'hA -> err one cycle, out stays 4'hA, out_valid=0.
REQ-030 PARITY_EN=1: 0,1,1,1,1,parity 0,stop 1 -> out=4'hF; same frame with parity 1 -> err, out unchanged.
REQ-031 rst_n=0 after 2 data bits, released after 2 cycles, then frame for 4'h2 -> no pulse during reset, out=4'h2 afterwards.
REQ-032 Two frames back-to-back (4'h5 then 4'h3), no idle bit between -> two out_valid pulses, final out=4'h3.
